decode_stage: RTL
=================

// Module: decode_stage
// PURPOSE
//  ID pipeline stage. Decodes RV32I instructions from fetch into the control encodings in
//  definitions_pkg (alu_e, branch_e, imm_e) that the execute stage consumes.
//  Sits between fetch and execute. Both sides use valid/ready handshakes.
//  Uses a 2-entry skid buffer (main + skid register), so in_ready is purely registered.
// PARAMETERS
//  XLEN      32  datapath width of in_pc/out_pc
//  EN_FENCE  1   1: FENCE/FENCE.I decode as NOP (ALU_ADD, no writes); 0: flagged illegal
// PORTS
//  clk          in   1     clock; all state updates on rising edge
//  rst          in   1     synchronous, active-high reset
//  flush        in   1     kill all buffered instructions (branch taken / trap)
//  in_valid     in   1     fetch presents in_instr/in_pc
//  in_ready     out  1     stage accepts; registered (= !skid_valid)
//  in_instr     in   32    raw instruction word
//  in_pc        in   XLEN  address of in_instr
//  out_valid    out  1     decoded bundle valid
//  out_ready    in   1     execute accepts bundle
//  out_pc       out  XLEN  pc of decoded instruction
//  rs1,rs2,rd   out  5 ea  register indices (instr[19:15],[24:20],[11:7])
//  alu_op       out  4     alu_e
//  br_op        out  4     branch_e (one-hot); 4'b0000 for non-branches
//  br_unsigned  out  1     BLTU/BGEU
//  imm_sel      out  3     imm_e
//  op_a_pc      out  1     ALU operand A = pc (AUIPC, JAL)
//  op_b_imm     out  1     ALU operand B = immediate
//  reg_we, mem_re, mem_we, is_branch, is_jump, illegal  out 1 ea  control flags
//  mem_size     out  3     funct3 of load/store
// BEHAVIOUR
//  - Decode is combinational on in_instr. The result is captured with in_pc into the main
//    register on in_valid&&in_ready. Latency is 1 cycle from accept to out_valid.
//  - Transfer out occurs on out_valid&&out_ready. If out is stalled while a new input is
//    accepted, the new bundle goes to the skid register. in_ready drops the next cycle.
//    On drain, skid moves to main, and in_ready rises the following cycle.
//  - Order is strictly FIFO. There is no bubble when out_ready stays high: throughput is
//    1 instruction per cycle.
//  - Simultaneous accept and drain with the skid empty: main is replaced by the new bundle.
//  - Reset: out_valid=0, skid empty, in_ready=1. All payload outputs are 0, and
//    alu_op=ALU_ADD, imm_sel=IMM_I_TYPE. Inputs are ignored while rst=1.
//  - flush (wins over accept): next cycle out_valid=0 and skid empty.
//    The in_valid of the flush cycle is dropped.
//  - Payload never drives X. ALU_XXX/BR_XXX/IMM_XXX are never emitted.
//  - Mapping:
//    - R/I ALU: funct3 selects ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND.
//      funct7[5] selects SUB (R only) and SRA/SRAI.
//    - LUI -> ALU_LUI, IMM_U_TYPE.
//    - AUIPC -> ALU_ADD, IMM_U_TYPE, op_a_pc.
//    - JAL -> ALU_ADD, IMM_JAL, op_a_pc, is_jump, reg_we.
//    - JALR -> ALU_ADD, IMM_I_TYPE, is_jump, reg_we.
//    - BEQ/BNE/BLT/BGE/BLTU/BGEU -> BR_EQ/NE/LT/GE/LT/GE, ALU_SUB, IMM_BRANCH, is_branch.
//      br_unsigned is set for BLTU/BGEU.
//    - LOAD -> ALU_ADD, IMM_I_TYPE, mem_re, reg_we.
//    - STORE -> ALU_ADD, IMM_STORE, mem_we.
//  - Illegal means any of: unknown opcode; instr[1:0]!=2'b11; bad funct3 for load, store
//    or branch; bad funct7 for R-type or shifts; SYSTEM; FENCE with EN_FENCE=0.
//    An illegal instruction sets illegal=1 and forces reg_we/mem_re/mem_we/is_branch/
//    is_jump to 0. It still flows through the handshake.
//  - reg_we is forced 0 when rd==0.
// TESTING
//  - ADD x3,x1,x2 (0x002081B3) with out_ready=1 -> next cycle out_valid=1, alu_op=ALU_ADD,
//    rd=3, reg_we=1.
//  - BLTU (0x0020E463) -> br_op=4'b0100, br_unsigned=1, imm_sel=IMM_BRANCH, is_branch=1.
//  - 3 back-to-back inputs, out_ready=0 on cycles 1-2 -> in_ready=0 after the 2nd accept;
//    all 3 emerge in order once out_ready=1, with no loss or duplicate.
//  - Skid full, then flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1,
//    and nothing from before the flush is emitted.
//  - 0xFFFFFFFF and 0x00000073 -> illegal=1, all write enables 0, alu_op=ALU_ADD (no X).
//  - rst asserted mid-stream with the buffer full -> next cycle out_valid=0, in_ready=1,
//    and payload is at reset values.

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode pipeline stage with a main+skid buffer between fetch and execute
// Ports: clk/rst (sync, active-high), flush; in_valid/in_ready/in_instr/in_pc from fetch;
// out_valid/out_ready and decoded bundle (out_pc, rs1, rs2, rd, alu_op, br_op, br_unsigned,
// imm_sel, op_a_pc, op_b_imm, reg_we, mem_re, mem_we, is_branch, is_jump, illegal, mem_size).
module decode_stage #(
  parameter int XLEN     = 32,
  parameter bit EN_FENCE = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [3:0]      alu_op,
  output logic [3:0]      br_op,
  output logic            br_unsigned,
  output logic [2:0]      imm_sel,
  output logic            op_a_pc,
  output logic            op_b_imm,
  output logic            reg_we,
  output logic            mem_re,
  output logic            mem_we,
  output logic            is_branch,
  output logic            is_jump,
  output logic            illegal,
  output logic [2:0]      mem_size
);
  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                         ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                         ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_LUI = 4'd10;
  localparam logic [2:0] IMM_I_TYPE = 3'd0, IMM_U_TYPE = 3'd1, IMM_JAL = 3'd2,
                         IMM_BRANCH = 3'd3, IMM_STORE = 3'd4;
  localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6f, OP_JALR = 7'h67,
                         OP_BRANCH = 7'h63, OP_LOAD = 7'h03, OP_STORE = 7'h23,
                         OP_IMM = 7'h13, OP_REG = 7'h33, OP_FENCE = 7'h0f;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1, rs2, rd;
    logic [3:0]      alu_op, br_op;
    logic            br_unsigned;
    logic [2:0]      imm_sel;
    logic            op_a_pc, op_b_imm, reg_we, mem_re, mem_we, is_branch, is_jump, illegal;
    logic [2:0]      mem_size;
  } bundle_t;
  // alt selects SUB (funct3=000) or SRA (funct3=101)
  function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
    return f3 == 3'd0 ? (alt ? ALU_SUB : ALU_ADD) :
           f3 == 3'd1 ? ALU_SLL :
           f3 == 3'd2 ? ALU_SLT :
           f3 == 3'd3 ? ALU_SLTU :
           f3 == 3'd4 ? ALU_XOR :
           f3 == 3'd5 ? (alt ? ALU_SRA : ALU_SRL) :
           f3 == 3'd6 ? ALU_OR : ALU_AND;
  endfunction
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic       bad, accept, drain, load_main, load_skid, main_v_d, skid_v_d;
  logic       main_v_q, skid_v_q;
  bundle_t    base, raw, dec, main_d, main_q, skid_q;
  assign opc = in_instr[6:0];
  assign f3  = in_instr[14:12];
  assign f7  = in_instr[31:25];
  always_comb begin
    base     = '0;
    base.pc  = in_pc;
    base.rs1 = in_instr[19:15];
    base.rs2 = in_instr[24:20];
    base.rd  = in_instr[11:7];
    raw      = base;
    bad      = 1'b0;
    case (opc)
      OP_LUI: begin
        raw.alu_op = ALU_LUI; raw.imm_sel = IMM_U_TYPE; raw.op_b_imm = 1'b1; raw.reg_we = 1'b1;
      end
      OP_AUIPC: begin
        raw.imm_sel = IMM_U_TYPE; raw.op_a_pc = 1'b1; raw.op_b_imm = 1'b1; raw.reg_we = 1'b1;
      end
      OP_JAL: begin
        raw.imm_sel = IMM_JAL; raw.op_a_pc = 1'b1; raw.op_b_imm = 1'b1;
        raw.is_jump = 1'b1; raw.reg_we = 1'b1;
      end
      OP_JALR: begin
        raw.op_b_imm = 1'b1; raw.is_jump = 1'b1; raw.reg_we = 1'b1;
      end
      OP_BRANCH: begin
        // one-hot {GE, LT, NE, EQ}; funct3[1] only distinguishes signedness
        raw.br_op       = {f3[2] & f3[0], f3[2] & ~f3[0], ~f3[2] & f3[0], ~f3[2] & ~f3[0]};
        raw.br_unsigned = f3[2] & f3[1];
        raw.alu_op      = ALU_SUB;
        raw.imm_sel     = IMM_BRANCH;
        raw.is_branch   = 1'b1;
        bad             = f3[2:1] == 2'b01;
      end
      OP_LOAD: begin
        raw.op_b_imm = 1'b1; raw.mem_re = 1'b1; raw.reg_we = 1'b1; raw.mem_size = f3;
        bad          = f3 == 3'd3 || f3[2:1] == 2'b11;
      end
      OP_STORE: begin
        raw.imm_sel = IMM_STORE; raw.op_b_imm = 1'b1; raw.mem_we = 1'b1; raw.mem_size = f3;
        bad         = f3[2] || f3[1:0] == 2'b11;
      end
      OP_IMM: begin
        raw.alu_op   = alu_of(f3, f3 == 3'd5 && f7[5]);
        raw.op_b_imm = 1'b1;
        raw.reg_we   = 1'b1;
        bad          = (f3 == 3'd1 && f7 != 7'd0) || (f3 == 3'd5 && {f7[6], f7[4:0]} != 6'd0);
      end
      OP_REG: begin
        raw.alu_op = alu_of(f3, f7[5]);
        raw.reg_we = 1'b1;
        bad        = {f7[6], f7[4:0]} != 6'd0 || (f7[5] && f3 != 3'd0 && f3 != 3'd5);
      end
      OP_FENCE: bad = !EN_FENCE;
      default:  bad = 1'b1;
    endcase
    dec        = raw;
    dec.reg_we = raw.reg_we && |raw.rd;
    if (bad) begin
      dec         = base;
      dec.illegal = 1'b1;
    end
  end
  assign in_ready  = !skid_v_q;
  assign out_valid = main_v_q;
  assign accept    = in_valid && !skid_v_q;
  assign drain     = main_v_q && out_ready;
  // with the skid occupied in_ready is low, so only skid->main moves can happen
  assign load_main = skid_v_q ? drain : accept && (!main_v_q || drain);
  assign load_skid = !skid_v_q && main_v_q && !drain && accept;
  assign main_d    = skid_v_q ? skid_q : dec;
  assign main_v_d  = skid_v_q || (main_v_q && !drain) || accept;
  assign skid_v_d  = skid_v_q ? !drain : load_skid;
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      main_q   <= '0;
      skid_q   <= '0;
    end else begin
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      if (load_main) main_q <= main_d;
      if (load_skid) skid_q <= dec;
    end
  end
  assign out_pc      = main_q.pc;
  assign rs1         = main_q.rs1;
  assign rs2         = main_q.rs2;
  assign rd          = main_q.rd;
  assign alu_op      = main_q.alu_op;
  assign br_op       = main_q.br_op;
  assign br_unsigned = main_q.br_unsigned;
  assign imm_sel     = main_q.imm_sel;
  assign op_a_pc     = main_q.op_a_pc;
  assign op_b_imm    = main_q.op_b_imm;
  assign reg_we      = main_q.reg_we;
  assign mem_re      = main_q.mem_re;
  assign mem_we      = main_q.mem_we;
  assign is_branch   = main_q.is_branch;
  assign is_jump     = main_q.is_jump;
  assign illegal     = main_q.illegal;
  assign mem_size    = main_q.mem_size;
endmodule
